unidade_decodificacao_pipe: RTL and testbench
=============================================

UNIDADE_DECODIFICACAO_PIPE -- requirements
Module: unidade_decodificacao_pipe

Interface
REQ-001 Parameter LARG_IMED, default 32, Imediato output width; legal range 19..64.
REQ-002 Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock.
REQ-004 Flush  in  1  synchronous discard of all held instructions.
REQ-005 EntradaValida  in  1  Instrucao is valid this cycle.
REQ-006 EntradaPronta  out  1  block can accept an instruction this cycle.
REQ-007 Instrucao  in  32  instruction word to decode.
REQ-008 SaidaValida  out  1  decoded fields valid this cycle.
REQ-009 SaidaPronta  in  1  consumer accepts decoded fields this cycle.
REQ-010 Cond  out  4; Opcode  out  8; RN, RD, RM  out  5 each; Imediato  out  LARG_IMED; Tipo  out  2 (Instrucao[27:26]).

Function
REQ-011 The decode map SHALL be selected by Instrucao[27:26]; Cond = Instrucao[31:28] in all four types.
REQ-012 Type 00 (D): Opcode=[27:20], RN=[19:15], RD=[14:10], RM=[9:5], Imediato=zero-extended [9:0].
REQ-013 Type 01 (B): Opcode={[27:24],4'b0}, RN=[23:19], RD=5'd31 (LR), RM=0, Imediato=extension of [18:0] per REQ-026/027.
REQ-014 Type 10 (M): Opcode={[27:23],3'b0}, RN=[22:18], RD=RM=[17:13], Imediato=zero-extended [12:0].
REQ-015 Type 11 (A): Opcode={[27:22],2'b0}, RN=RD=[21:17], RM=0, Imediato=0.
REQ-016 Transfers SHALL occur on EntradaValida&EntradaPronta (input) and SaidaValida&SaidaPronta (output).
REQ-017 Latency SHALL be exactly 1 cycle: an instruction accepted in cycle N is presented with SaidaValida=1 in cycle N+1 if the output stage is free.
REQ-018 Storage SHALL be a 2-entry skid buffer (output register + skid register); EntradaPronta SHALL be a registered signal equal to "skid register empty".
REQ-019 With SaidaPronta held 1, throughput SHALL be one instruction per cycle with no bubbles.
REQ-020 Output order SHALL equal acceptance order; no instruction is dropped or duplicated except by Flush/reset.
REQ-021 Output fields SHALL hold stable while SaidaValida=1 and SaidaPronta=0.
REQ-022 Full: with both entries occupied, EntradaPronta=0; a pop in that cycle moves skid to output and EntradaPronta returns to 1 the next cycle.
REQ-023 Simultaneous push and pop with one entry held: the popped entry is replaced by the new one; occupancy unchanged.
REQ-024 Flush=1 SHALL empty both entries next cycle (SaidaValida=0, EntradaPronta=1); an instruction offered in the Flush cycle SHALL be discarded; Flush has priority over push and pop.
REQ-025 Output data values when SaidaValida=0 are don't-care, except after reset (REQ-028).

Configuration
REQ-026 With macro UNIDADE_DECOD_EXT_SINAL_EN defined, type-B Imediato SHALL be sign-extended from Instrucao[18] to LARG_IMED bits.
REQ-027 Without UNIDADE_DECOD_EXT_SINAL_EN, type-B Imediato SHALL be zero-extended; all other types unaffected either way.

Reset
REQ-028 While Reset_n=0 at a rising edge: both entries emptied, SaidaValida=0, EntradaPronta=0, Cond, Opcode, RN, RD, RM, Imediato, Tipo = 0.
REQ-029 EntradaPronta SHALL be 1 in the first cycle after Reset_n is sampled 1.
REQ-030 Reset asserted mid-operation SHALL discard all held instructions; Reset has priority over Flush.

Verification
REQ-031 Push 0x00123456, SaidaPronta=1 -> next cycle SaidaValida=1, Tipo=0, Cond=0, Opcode=0x01, RN=4, RD=13, RM=2, Imediato=0x056.
REQ-032 Push 0x0A4A2005 -> Tipo=2, Opcode=0xA0, RN=18, RD=17, RM=17, Imediato=0x0005; push 0xEC000000 -> Tipo=3, Cond=0xE, Opcode=0xC0, RN=RD=RM=0, Imediato=0.
REQ-033 Push 0xE5FFFFFF -> Opcode=0x50, RN=31, RD=31, RM=0, Imediato=0xFFFFFFFF with macro, 0x0007FFFF without.
REQ-034 Hold SaidaPronta=0, push A,B,C back-to-back -> A,B accepted, EntradaPronta=0 while C is offered, fields of A stable; raise SaidaPronta -> outputs A,B,C in order, C accepted once EntradaPronta returns to 1.
REQ-035 Two entries held, assert Flush together with a push -> next cycle SaidaValida=0, EntradaPronta=1, and the pushed instruction never appears at the output.
REQ-036 Reset_n=0 for one cycle with two entries held -> all outputs 0, EntradaPronta=0 during reset, 1 in the first cycle after release.

Source files
------------

// File: rtl/unidade_decodificacao_pipe_if.sv
// Handshake and decoded-field bundle for unidade_decodificacao_pipe.
// master drives instructions/flush and consumes fields; slave is the decoder.
interface unidade_decodificacao_pipe_if #(
  parameter int unsigned LARG_IMED = 32
);
  logic                 Flush;
  logic                 EntradaValida;
  logic                 EntradaPronta;
  logic [31:0]          Instrucao;
  logic                 SaidaValida;
  logic                 SaidaPronta;
  logic [3:0]           Cond;
  logic [7:0]           Opcode;
  logic [4:0]           RN;
  logic [4:0]           RD;
  logic [4:0]           RM;
  logic [LARG_IMED-1:0] Imediato;
  logic [1:0]           Tipo;

  modport master (
    output Flush, EntradaValida, Instrucao, SaidaPronta,
    input  EntradaPronta, SaidaValida, Cond, Opcode, RN, RD, RM, Imediato, Tipo
  );

  modport slave (
    input  Flush, EntradaValida, Instrucao, SaidaPronta,
    output EntradaPronta, SaidaValida, Cond, Opcode, RN, RD, RM, Imediato, Tipo
  );
endinterface

// File: rtl/unidade_decodificacao_pipe.sv
// Instruction decoder with a 2-entry skid buffer (output + skid register), 1-cycle latency.
// Optional macro UNIDADE_DECOD_EXT_SINAL_EN: sign-extend the type-B immediate.
module unidade_decodificacao_pipe #(
  parameter int unsigned LARG_IMED = 32
) (
  input logic                          Clock,
  input logic                          Reset_n,
  unidade_decodificacao_pipe_if.slave  bus
);

  typedef struct packed {
    logic [3:0]           cond;
    logic [7:0]           opcode;
    logic [4:0]           rn;
    logic [4:0]           rd;
    logic [4:0]           rm;
    logic [LARG_IMED-1:0] imed;
    logic [1:0]           tipo;
  } campos_t;

  function automatic campos_t decodifica(input logic [31:0] ins);
    campos_t c;
    c      = '0;
    c.cond = ins[31:28];
    c.tipo = ins[27:26];
    case (ins[27:26])
      2'b00: begin
        c.opcode = ins[27:20];
        c.rn     = ins[19:15];
        c.rd     = ins[14:10];
        c.rm     = ins[9:5];
        c.imed   = LARG_IMED'(ins[9:0]);
      end
      2'b01: begin
        c.opcode = {ins[27:24], 4'b0000};
        c.rn     = ins[23:19];
        c.rd     = 5'd31;
`ifdef UNIDADE_DECOD_EXT_SINAL_EN
        c.imed   = LARG_IMED'($signed(ins[18:0]));
`else
        c.imed   = LARG_IMED'(ins[18:0]);
`endif
      end
      2'b10: begin
        c.opcode = {ins[27:23], 3'b000};
        c.rn     = ins[22:18];
        c.rd     = ins[17:13];
        c.rm     = ins[17:13];
        c.imed   = LARG_IMED'(ins[12:0]);
      end
      default: begin
        c.opcode = {ins[27:22], 2'b00};
        c.rn     = ins[21:17];
        c.rd     = ins[21:17];
      end
    endcase
    return c;
  endfunction

  campos_t r_saida_q, r_skid_q;
  logic    r_val_saida_q, r_val_skid_q, r_pronta_q;

  campos_t w_saida_d, w_skid_d, w_dec;
  logic    w_val_saida_d, w_val_skid_d, w_pronta_d;
  logic    w_push, w_pop;

  assign w_dec  = decodifica(bus.Instrucao);
  assign w_push = bus.EntradaValida & r_pronta_q;
  assign w_pop  = r_val_saida_q & bus.SaidaPronta;

  always_comb begin
    w_saida_d     = r_saida_q;
    w_skid_d      = r_skid_q;
    w_val_saida_d = r_val_saida_q;
    w_val_skid_d  = r_val_skid_q;
    if (bus.Flush) begin
      w_val_saida_d = 1'b0;
      w_val_skid_d  = 1'b0;
    end else if (r_val_skid_q) begin
      // Full: no push possible (EntradaPronta is low); a pop drains skid into output.
      if (w_pop) begin
        w_saida_d    = r_skid_q;
        w_val_skid_d = 1'b0;
      end
    end else if (r_val_saida_q) begin
      if (w_pop && w_push) begin
        w_saida_d = w_dec;
      end else if (w_pop) begin
        w_val_saida_d = 1'b0;
      end else if (w_push) begin
        w_skid_d     = w_dec;
        w_val_skid_d = 1'b1;
      end
    end else if (w_push) begin
      w_saida_d     = w_dec;
      w_val_saida_d = 1'b1;
    end
    w_pronta_d = ~w_val_skid_d;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_saida_q     <= '0;
      r_skid_q      <= '0;
      r_val_saida_q <= 1'b0;
      r_val_skid_q  <= 1'b0;
      r_pronta_q    <= 1'b0;
    end else begin
      r_saida_q     <= w_saida_d;
      r_skid_q      <= w_skid_d;
      r_val_saida_q <= w_val_saida_d;
      r_val_skid_q  <= w_val_skid_d;
      r_pronta_q    <= w_pronta_d;
    end
  end

  assign bus.EntradaPronta = r_pronta_q;
  assign bus.SaidaValida   = r_val_saida_q;
  assign bus.Cond          = r_saida_q.cond;
  assign bus.Opcode        = r_saida_q.opcode;
  assign bus.RN            = r_saida_q.rn;
  assign bus.RD            = r_saida_q.rd;
  assign bus.RM            = r_saida_q.rm;
  assign bus.Imediato      = r_saida_q.imed;
  assign bus.Tipo          = r_saida_q.tipo;

endmodule

// File: tb/tb_unidade_decodificacao_pipe.sv
// Bench for unidade_decodificacao_pipe: directed scenarios plus random traffic,
// checked against a queue-based model of the held instructions.
module tb_unidade_decodificacao_pipe;
  localparam int unsigned LARG = 32;
`ifdef UNIDADE_DECOD_EXT_SINAL_EN
  localparam bit SINAL = 1'b1;
`else
  localparam bit SINAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unidade_decodificacao_pipe_if #(.LARG_IMED(LARG)) bus ();

  unidade_decodificacao_pipe #(.LARG_IMED(LARG)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0]  cond;
    logic [7:0]  op;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [4:0]  rm;
    logic [63:0] imm;
    logic [1:0]  tipo;
  } ref_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fila[$];
  bit          em_reset = 1'b1;

  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t        r;
    logic [63:0] v;
    r.cond = 4'((ins >> 28) & 32'hF);
    r.tipo = 2'((ins >> 26) & 32'h3);
    r.rm   = '0;
    case (r.tipo)
      2'd0: begin
        r.op = 8'((ins >> 20) & 32'hFF);
        r.rn = 5'((ins >> 15) & 32'h1F);
        r.rd = 5'((ins >> 10) & 32'h1F);
        r.rm = 5'((ins >> 5) & 32'h1F);
        v    = 64'(ins & 32'h3FF);
      end
      2'd1: begin
        r.op = 8'(((ins >> 24) & 32'hF) * 16);
        r.rn = 5'((ins >> 19) & 32'h1F);
        r.rd = 5'd31;
        v    = 64'(ins & 32'h7FFFF);
        if (SINAL && v >= 64'h40000) v = v - 64'h80000;
      end
      2'd2: begin
        r.op = 8'(((ins >> 23) & 32'h1F) * 8);
        r.rn = 5'((ins >> 18) & 32'h1F);
        r.rd = 5'((ins >> 13) & 32'h1F);
        r.rm = r.rd;
        v    = 64'(ins & 32'h1FFF);
      end
      default: begin
        r.op = 8'(((ins >> 22) & 32'h3F) * 4);
        r.rn = 5'((ins >> 17) & 32'h1F);
        r.rd = r.rn;
        v    = 64'd0;
      end
    endcase
    if (LARG < 64) v = v & ((64'd1 << LARG) - 64'd1);
    r.imm = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_saidas();
    ref_t e;
    chk("EntradaPronta", 64'(bus.EntradaPronta), 64'(!em_reset && fila.size() < 2));
    chk("SaidaValida", 64'(bus.SaidaValida), 64'(fila.size() > 0));
    if (em_reset) begin
      chk("reset_campos", {bus.Cond, bus.Opcode, bus.RN, bus.RD, bus.RM, bus.Tipo},
          64'd0);
      chk("reset_imed", 64'(bus.Imediato), 64'd0);
    end else if (fila.size() > 0) begin
      e = ref_decode(fila[0]);
      chk("Cond", 64'(bus.Cond), 64'(e.cond));
      chk("Opcode", 64'(bus.Opcode), 64'(e.op));
      chk("RN_RD_RM", {bus.RN, bus.RD, bus.RM}, {e.rn, e.rd, e.rm});
      chk("Imediato", 64'(bus.Imediato), e.imm);
      chk("Tipo", 64'(bus.Tipo), 64'(e.tipo));
    end
  endtask

  // One clock: drive, advance model at the edge, then check at the falling edge.
  task automatic ciclo(input bit v, input logic [31:0] ins, input bit sp, input bit fl,
                       input bit rn);
    bit pronta, push, pop;
    bus.EntradaValida = v;
    bus.Instrucao     = ins;
    bus.SaidaPronta   = sp;
    bus.Flush         = fl;
    rst_n             = rn;
    pronta = !em_reset && fila.size() < 2;
    @(posedge clk);
    if (!rn) begin
      fila.delete();
      em_reset = 1'b1;
    end else begin
      em_reset = 1'b0;
      if (fl) fila.delete();
      else begin
        pop  = fila.size() > 0 && sp;
        push = v && pronta;
        if (pop) void'(fila.pop_front());
        if (push) fila.push_back(ins);
      end
    end
    @(negedge clk);
    chk_saidas();
  endtask

  initial begin
    logic [31:0] a, b, c;
    bus.EntradaValida = 1'b0;
    bus.Instrucao     = '0;
    bus.SaidaPronta   = 1'b0;
    bus.Flush         = 1'b0;
    rst_n             = 1'b0;
    @(negedge clk);

    // Reset state, then ready on the first cycle after release
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("pronta_pos_reset", 64'(bus.EntradaPronta), 64'd1);

    // Directed decodes with literal expectations
    ciclo(1'b1, 32'h00123456, 1'b1, 1'b0, 1'b1);
    chk("d_valida", 64'(bus.SaidaValida), 64'd1);
    chk("d_campos", {bus.Tipo, bus.Cond, bus.Opcode, bus.RN, bus.RD, bus.RM},
        {2'd0, 4'd0, 8'h01, 5'd4, 5'd13, 5'd2});
    chk("d_imed", 64'(bus.Imediato), 64'h56);
    ciclo(1'b1, 32'h0A4A2005, 1'b1, 1'b0, 1'b1);
    chk("m_campos", {bus.Tipo, bus.Opcode, bus.RN, bus.RD, bus.RM, bus.Imediato},
        {2'd2, 8'hA0, 5'd18, 5'd17, 5'd17, 32'h5});
    ciclo(1'b1, 32'hEC000000, 1'b1, 1'b0, 1'b1);
    chk("a_campos", {bus.Tipo, bus.Cond, bus.Opcode, bus.RN, bus.RD, bus.RM, bus.Imediato},
        {2'd3, 4'hE, 8'hC0, 15'd0, 32'd0});
    ciclo(1'b1, 32'hE5FFFFFF, 1'b1, 1'b0, 1'b1);
    chk("b_campos", {bus.Opcode, bus.RN, bus.RD, bus.RM}, {8'h50, 5'd31, 5'd31, 5'd0});
    chk("b_imed", 64'(bus.Imediato), SINAL ? 64'hFFFFFFFF : 64'h0007FFFF);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: A,B fill the buffer, C waits until the skid drains
    a = 32'h00123456; b = 32'h0A4A2005; c = 32'hE5FFFFFF;
    ciclo(1'b1, a, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, b, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, c, 1'b0, 1'b0, 1'b1);
    chk("cheio_pronta", 64'(bus.EntradaPronta), 64'd0);
    chk("cheio_estavel", 64'(bus.Opcode), 64'h01);
    ciclo(1'b1, c, 1'b1, 1'b0, 1'b1);
    chk("drena_pronta", 64'(bus.EntradaPronta), 64'd1);
    ciclo(1'b1, c, 1'b1, 1'b0, 1'b1);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("c_saida", 64'(bus.Opcode), 64'h50);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("vazio", 64'(bus.SaidaValida), 64'd0);

    // Flush with two held and a push offered
    ciclo(1'b1, a, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, b, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, c, 1'b1, 1'b1, 1'b1);
    chk("flush_valida", 64'(bus.SaidaValida), 64'd0);
    chk("flush_pronta", 64'(bus.EntradaPronta), 64'd1);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with two held, with Flush also asserted
    ciclo(1'b1, a, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, b, 1'b0, 1'b0, 1'b1);
    ciclo(1'b1, c, 1'b1, 1'b1, 1'b0);
    ciclo(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ciclo(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 20) == 0, ($urandom % 80) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
